fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, giving the number of producer ports (2..8).
REQ-002 The block SHALL have parameter DW, default 8, giving the data width.
REQ-003 The block SHALL have parameter DEPTH, default 16, giving the capacity of the downstream FIFO in entries.
REQ-004 The block SHALL have port clk, input, 1 bit: clock, all state on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port req_valid, input, NREQ bits: per-producer data valid.
REQ-007 The block SHALL have port req_data, input, NREQ*DW bits: producer i data in bits [i*DW +: DW].
REQ-008 The block SHALL have port req_ready, output, NREQ bits: per-producer accept, one-hot or zero.
REQ-009 The block SHALL have port fifo_rd, input, 1 bit: consumer read strobe, the same signal that drives the FIFO read enable.
REQ-010 The block SHALL have port fifo_wr_en, output, 1 bit: registered FIFO write enable.
REQ-011 The block SHALL have port fifo_wr_data, output, DW bits: registered FIFO write data.
REQ-012 The block SHALL have port grant_id, output, 3 bits: index of the last producer granted.
REQ-013 The block SHALL have port count, output, 5 bits: current FIFO occupancy.
REQ-014 The block SHALL have ports full, empty, underflow_err, output, 1 bit each.

Function
REQ-015 A transfer SHALL occur in a cycle where req_valid[i] and req_ready[i] are both high.
REQ-016 req_ready SHALL be combinational from req_valid, the priority pointer and count.
REQ-017 req_ready SHALL be all-zero when count == DEPTH, including when fifo_rd is high in the same cycle.
REQ-018 At most one req_ready bit SHALL be high per cycle, and only for a producer with req_valid high.
REQ-019 Round-robin: the search SHALL start at index (grant_id+1) mod NREQ; the first valid index found wins.
REQ-020 grant_id SHALL update to the winning index only on a transfer and otherwise hold.
REQ-021 On a transfer, fifo_wr_en SHALL be 1 and fifo_wr_data SHALL equal the winner's data on the next edge (1-cycle latency); otherwise fifo_wr_en SHALL be 0 and fifo_wr_data SHALL hold.
REQ-022 count SHALL be +1 on a transfer without a valid read, -1 on a valid read without a transfer, and unchanged when both or neither occur.
REQ-023 A valid read SHALL be fifo_rd with count > 0.
REQ-024 fifo_rd with count == 0 SHALL leave count at 0 and pulse underflow_err high for one cycle.
REQ-025 full SHALL equal (count == DEPTH) and empty SHALL equal (count == 0), both combinational from count.
REQ-026 count SHALL never exceed DEPTH or wrap below 0.
REQ-027 A producer SHALL be able to hold req_valid across cycles; its data is consumed only on its ready cycle.

Reset
REQ-028 While reset is high at an edge: count=0, fifo_wr_en=0, fifo_wr_data=0, underflow_err=0, grant_id=NREQ-1 (so producer 0 wins first); req_ready SHALL be all-zero during the reset cycle.
REQ-029 Reset mid-operation SHALL discard any pending registered write (fifo_wr_en=0 on the next edge); the FIFO is reset by the same reset signal.

Configuration
REQ-030 The macro FIFO_WR_ARB_FIXED_PRIORITY_EN SHALL control the grant policy.
REQ-031 When FIFO_WR_ARB_FIXED_PRIORITY_EN is defined, the lowest-index valid producer SHALL always win, and grant_id SHALL still report the winner.
REQ-032 When FIFO_WR_ARB_FIXED_PRIORITY_EN is undefined, round-robin per REQ-019 SHALL apply.

Verification
REQ-033 Reset, then req_valid=4'b1111 held with fifo_rd=0 -> grants in order 0,1,2,3,0,...; fifo_wr_en high each cycle after the first; count reaches 16, then full=1 and req_ready=0.
REQ-034 count=16, fifo_rd=1 and req_valid=4'b0001 -> no grant that cycle; count=15 next cycle; producer 0 granted the following cycle; count returns to 16.
REQ-035 count=5 with a transfer and fifo_rd in the same cycle -> count stays 5; fifo_wr_data equals the winner's data one cycle later.
REQ-036 count=0, fifo_rd=1 -> count stays 0; underflow_err is high for exactly one cycle.
REQ-037 Transfer in progress, reset asserted -> next edge: fifo_wr_en=0, count=0, grant_id=3; the next grant goes to producer 0.
REQ-038 With FIFO_WR_ARB_FIXED_PRIORITY_EN defined, req_valid=4'b1010 held -> producer 1 is granted every cycle and producer 3 is never granted until req_valid[1] drops.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Multi-producer write arbiter feeding a DEPTH-entry FIFO. It tracks FIFO occupancy and registers the write.
// The grant policy is round-robin by default. Define FIFO_WR_ARB_FIXED_PRIORITY_EN to make the lowest index always win.
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [NREQ*DW-1:0]  req_data,
  output logic [NREQ-1:0]     req_ready,
  input  logic                fifo_rd,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_wr_data,
  output logic [2:0]          grant_id,
  output logic [4:0]          count,
  output logic                full,
  output logic                empty,
  output logic                underflow_err
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [DW-1:0] data_arr [NREQ];
  logic [IW-1:0] ptr;
  logic [IW-1:0] cand_idx;
  logic [IW-1:0] win_idx;
  logic          win_found;
  logic          transfer;
  logic          rd_ok;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign data_arr[i] = req_data[i*DW +: DW];
  end

  // The search runs over NREQ candidates. The first candidate with valid set wins.
  always_comb begin
    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand_idx  = '0;
    for (int k = 0; k < NREQ; k++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIORITY_EN
      cand_idx = IW'(k);
`else
      cand_idx = IW'((int'(ptr) + 1 + k) % NREQ);
`endif
      if (!win_found && req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  assign full      = (count == 5'(DEPTH));
  assign empty     = (count == 5'd0);
  assign req_ready = (win_found && !reset && !full) ? (NREQ'(1) << win_idx) : '0;
  assign transfer  = |(req_valid & req_ready);
  assign rd_ok     = fifo_rd && !empty;
  assign grant_id  = 3'(ptr);

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values regardless of statement order.
    if (reset) begin
      count         <= '0;
      fifo_wr_en    <= 1'b0;
      fifo_wr_data  <= '0;
      underflow_err <= 1'b0;
      ptr           <= IW'(NREQ - 1);
    end else begin
      fifo_wr_en    <= transfer;
      underflow_err <= fifo_rd && empty;
      if (transfer) begin
        fifo_wr_data <= data_arr[win_idx];
        ptr          <= win_idx;
      end
      // When a write and a read land in the same cycle, the occupancy does not change.
      if (transfer && !rd_ok)
        count <= count + 5'd1;
      else if (rd_ok && !transfer)
        count <= count - 5'd1;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8, DEPTH=16).
// Expectations follow FIFO_WR_ARB_FIXED_PRIORITY_EN when the bench is built with it.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_rd;
  logic        fifo_wr_en;
  logic [7:0]  fifo_wr_data;
  logic [2:0]  grant_id;
  logic [4:0]  count;
  logic        full;
  logic        empty;
  logic        underflow_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NREQ(4), .DW(8), .DEPTH(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .fifo_rd(fifo_rd), .fifo_wr_en(fifo_wr_en),
    .fifo_wr_data(fifo_wr_data), .grant_id(grant_id), .count(count),
    .full(full), .empty(empty), .underflow_err(underflow_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge. Inputs change and outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e;
    reset     = 1'b1;
    req_valid = 4'b1111;
    req_data  = 32'h44332211;   // producer i carries 8'h11*(i+1)
    fifo_rd   = 1'b0;
    #1;
    check("ready_during_reset", req_ready, 4'b0000);
    tick();
    tick();
    check("rst_count", count, 0);
    check("rst_wr_en", fifo_wr_en, 0);
    check("rst_wr_data", fifo_wr_data, 0);
    check("rst_underflow", underflow_err, 0);
    check("rst_grant_id", grant_id, 3);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);

    // Fill to DEPTH with all producers valid.
    reset = 1'b0;
    #1;
    for (int n = 0; n < 16; n++) begin
`ifdef FIFO_WR_ARB_FIXED_PRIORITY_EN
      e = 0;
`else
      e = n % 4;
`endif
      check($sformatf("fill_ready_%0d", n), req_ready, 4'b0001 << e);
      tick();
      check($sformatf("fill_wr_en_%0d", n), fifo_wr_en, 1);
      check($sformatf("fill_data_%0d", n), fifo_wr_data, 8'h11 * (e + 1));
      check($sformatf("fill_grant_%0d", n), grant_id, e);
      check($sformatf("fill_count_%0d", n), count, n + 1);
    end
    check("full_flag", full, 1);
    check("full_ready_zero", req_ready, 4'b0000);
    tick();
    check("full_hold_count", count, 16);
    check("full_no_wr", fifo_wr_en, 0);
`ifdef FIFO_WR_ARB_FIXED_PRIORITY_EN
    check("full_data_hold", fifo_wr_data, 8'h11);
`else
    check("full_data_hold", fifo_wr_data, 8'h44);
`endif

    // A read while full frees a slot. The ready stays low until the next cycle.
    req_valid = 4'b0001;
    fifo_rd   = 1'b1;
    #1;
    check("full_rd_ready_zero", req_ready, 4'b0000);
    tick();
    check("after_rd_count", count, 15);
    fifo_rd = 1'b0;
    #1;
    check("refill_ready", req_ready, 4'b0001);
    tick();
    check("refill_count", count, 16);
    check("refill_grant", grant_id, 0);
    check("refill_data", fifo_wr_data, 8'h11);

    // Drain to 5, then write and read in the same cycle.
    req_valid = 4'b0000;
    fifo_rd   = 1'b1;
    for (int n = 0; n < 11; n++) tick();
    check("drain_count5", count, 5);
    req_valid = 4'b0100;
    #1;
    check("simul_ready", req_ready, 4'b0100);
    tick();
    check("simul_count", count, 5);
    check("simul_wr_en", fifo_wr_en, 1);
    check("simul_data", fifo_wr_data, 8'h33);
    check("simul_grant", grant_id, 2);

    // Drain to empty, then read once more to trigger an underflow.
    req_valid = 4'b0000;
    for (int n = 0; n < 5; n++) tick();
    check("drain_count0", count, 0);
    check("drain_empty", empty, 1);
    check("no_underflow_yet", underflow_err, 0);
    tick();
    check("uf_count", count, 0);
    check("uf_pulse", underflow_err, 1);
    fifo_rd = 1'b0;
    tick();
    check("uf_clear", underflow_err, 0);
    check("uf_count_hold", count, 0);

    // Two producers held valid; the grant_id pointer starts at 2.
    req_valid = 4'b1010;
    #1;
`ifdef FIFO_WR_ARB_FIXED_PRIORITY_EN
    check("pair_ready_a", req_ready, 4'b0010);
    tick();
    check("pair_grant_a", grant_id, 1);
    check("pair_ready_b", req_ready, 4'b0010);
    tick();
    check("pair_grant_b", grant_id, 1);
    req_valid = 4'b1000;
`else
    check("pair_ready_a", req_ready, 4'b1000);
    tick();
    check("pair_grant_a", grant_id, 3);
    check("pair_ready_b", req_ready, 4'b0010);
    tick();
    check("pair_grant_b", grant_id, 1);
`endif
    #1;
    check("pair_ready_c", req_ready, 4'b1000);
    tick();
    check("pair_grant_c", grant_id, 3);
    check("pair_data_c", fifo_wr_data, 8'h44);
    check("pair_count", count, 3);

    // Reset arrives while a registered write is pending.
    req_valid = 4'b1111;
    tick();
    check("pre_rst_wr_en", fifo_wr_en, 1);
    check("pre_rst_count", count, 4);
    reset = 1'b1;
    #1;
    check("mid_rst_ready_zero", req_ready, 4'b0000);
    tick();
    check("mid_rst_wr_en", fifo_wr_en, 0);
    check("mid_rst_count", count, 0);
    check("mid_rst_grant", grant_id, 3);
    reset = 1'b0;
    #1;
    check("post_rst_ready", req_ready, 4'b0001);
    tick();
    check("post_rst_grant", grant_id, 0);
    check("post_rst_data", fifo_wr_data, 8'h11);
    check("post_rst_count", count, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
